// File: rtl/sky130_as_sc_hs_bist.sv
// BIST engine for the sky130_as_sc_hs cell set: Galois LFSR stimulus, MISR response compaction.
// Optional golden-signature comparator enabled by defining SC_HS_BIST_CMP_EN.
module sky130_as_sc_hs_bist #(
  parameter int unsigned NUM_PATTERNS = 256,
  parameter int unsigned RESP_LAT     = 1,
  parameter logic [15:0] GOLDEN       = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        ABORT,
  output logic [15:0] STIM,
  input  logic [15:0] RESP,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] SIGNATURE,
  output logic        PASS
);

  localparam int unsigned W  = 16;
  localparam int unsigned FW = 2;
  localparam logic [W-1:0]  LFSR_SEED  = 16'hACE1;
  localparam logic [W-1:0]  POLY       = 16'hB400;
  localparam logic [W-1:0]  LAST_PAT   = W'(NUM_PATTERNS - 1);
  localparam logic [W-1:0]  LAT_W      = W'(RESP_LAT);
  localparam logic [FW-1:0] LAST_FLUSH = FW'(RESP_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  function automatic logic [W-1:0] galois(input logic [W-1:0] v);
    return {1'b0, v[W-1:1]} ^ (v[0] ? POLY : '0);
  endfunction

  state_t          state_q, state_d;
  logic [W-1:0]    lfsr_q, lfsr_d;
  logic [W-1:0]    misr_q, misr_d;
  logic [W-1:0]    pat_q, pat_d;
  logic [FW-1:0]   flush_q, flush_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Next-state, datapath and registered-output decode; ABORT overrides everything.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    pat_d   = pat_q;
    flush_d = flush_q;
    if (ABORT) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (START) state_d = S_SEED;
        end
        S_SEED: begin
          lfsr_d  = LFSR_SEED;
          misr_d  = '0;
          pat_d   = '0;
          flush_d = '0;
          state_d = S_RUN;
        end
        S_RUN: begin
          lfsr_d = galois(lfsr_q);
          pat_d  = pat_q + W'(1);
          // Responses to the first RESP_LAT vectors are still in the CUT pipeline.
          if (pat_q >= LAT_W) misr_d = galois(misr_q) ^ RESP;
          if (pat_q == LAST_PAT) state_d = (RESP_LAT == 0) ? S_DONE : S_FLUSH;
        end
        S_FLUSH: begin
          misr_d  = galois(misr_q) ^ RESP;
          flush_d = flush_q + FW'(1);
          if (flush_q == LAST_FLUSH) state_d = S_DONE;
        end
        S_DONE: begin
          if (START) state_d = S_SEED;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_SEED) || (state_d == S_RUN) || (state_d == S_FLUSH);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= '0;
      pat_q   <= '0;
      flush_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      pat_q   <= pat_d;
      flush_q <= flush_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign STIM      = lfsr_q;
  assign SIGNATURE = misr_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

`ifdef SC_HS_BIST_CMP_EN
  logic pass_q, pass_d;

  // Verdict is latched on entry to DONE and held until the next seed or abort.
  always_comb begin
    pass_d = pass_q;
    if (ABORT || (state_d == S_SEED)) begin
      pass_d = 1'b0;
    end else if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      pass_d = (misr_d == GOLDEN);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pass_q <= 1'b0;
    else        pass_q <= pass_d;
  end

  assign PASS = pass_q;
`else
  logic unused_golden;
  assign unused_golden = ^GOLDEN;
  assign PASS = 1'b0;
`endif

endmodule

// File: tb/tb_sky130_as_sc_hs_bist.sv
// Self-checking bench for sky130_as_sc_hs_bist: directed run sequence with random and loopback
// responses checked against a signature model derived from the absorption-window rule.
module tb_sky130_as_sc_hs_bist;

  localparam int unsigned NP_A   = 16;
  localparam int unsigned LAT_A  = 2;
  localparam logic [15:0] GOLD_A = 16'h0000;
  localparam int unsigned NP_B   = 3;
  localparam int unsigned LAT_B  = 0;
  localparam int M_RAND = 0;
  localparam int M_ZERO = 1;
  localparam int M_LOOP = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, abort_a, start_b, abort_b;
  logic [15:0] resp_a, resp_b;
  logic [15:0] stim_a, stim_b, sig_a, sig_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic        sel;
  logic [15:0] stim_m, sig_m;
  logic        busy_m, done_m, pass_m;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] stim_model [0:NP_A];

  always #5 clk = ~clk;

  sky130_as_sc_hs_bist #(.NUM_PATTERNS(NP_A), .RESP_LAT(LAT_A), .GOLDEN(GOLD_A)) u_dut_a (
    .CLK(clk), .RST_N(rst_n), .START(start_a), .ABORT(abort_a), .STIM(stim_a), .RESP(resp_a),
    .BUSY(busy_a), .DONE(done_a), .SIGNATURE(sig_a), .PASS(pass_a));

  sky130_as_sc_hs_bist #(.NUM_PATTERNS(NP_B), .RESP_LAT(LAT_B), .GOLDEN(GOLD_A)) u_dut_b (
    .CLK(clk), .RST_N(rst_n), .START(start_b), .ABORT(abort_b), .STIM(stim_b), .RESP(resp_b),
    .BUSY(busy_b), .DONE(done_b), .SIGNATURE(sig_b), .PASS(pass_b));

  assign stim_m = sel ? stim_b : stim_a;
  assign sig_m  = sel ? sig_b  : sig_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign done_m = sel ? done_b : done_a;
  assign pass_m = sel ? pass_b : pass_a;

  function automatic logic [15:0] galois(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic pass_expect(input logic [15:0] s);
`ifdef SC_HS_BIST_CMP_EN
    return (s == GOLD_A);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic ab, input logic [15:0] r);
    if (sel) begin start_b = st; abort_b = ab; resp_b = r; end
    else     begin start_a = st; abort_a = ab; resp_a = r; end
  endtask

  task automatic check_reset(input string tag);
    chk16({tag, "_stim_a"}, stim_a, 16'hACE1);
    chk16({tag, "_sig_a"}, sig_a, 16'h0000);
    chk1({tag, "_busy_a"}, busy_a, 1'b0);
    chk1({tag, "_done_a"}, done_a, 1'b0);
    chk1({tag, "_pass_a"}, pass_a, 1'b0);
    chk16({tag, "_stim_b"}, stim_b, 16'hACE1);
    chk1({tag, "_busy_b"}, busy_b, 1'b0);
  endtask

  // One full run on the selected DUT; the signature model folds whatever RESP was driven
  // in the window of RUN-relative cycles [lat, np+lat), which is where valid responses land.
  task automatic run(input int np, input int lat, input int mode, input int abort_at,
                     input int flip_at, input bit hold_start,
                     output logic [15:0] exp_sig, output logic [15:0] obs_sig);
    logic [15:0] hist [$];
    logic [15:0] r;
    logic [15:0] s;
    logic        st;
    s = 16'h0000;
    obs_sig = 16'hxxxx;
    @(posedge clk); #1 drive(1'b1, 1'b0, 16'h0000);
    @(posedge clk); #1;
    st = hold_start;
    drive(st, 1'b0, 16'h0000);
    chk1("seed_busy", busy_m, 1'b1);
    chk1("seed_done", done_m, 1'b0);
    chk1("seed_pass", pass_m, 1'b0);
    for (int c = 0; c <= np + lat; c++) begin
      @(posedge clk); #1;
      if (c < np + lat) begin
        chk1("run_busy", busy_m, 1'b1);
        chk1("run_done", done_m, 1'b0);
        chk16("run_stim", stim_m, stim_model[(c < np) ? c : np]);
        hist.push_back(stim_m);
        if (c == abort_at) begin
          drive(st, 1'b1, 16'h0000);
          @(posedge clk); #1 drive(1'b0, 1'b0, 16'h0000);
          chk1("abort_busy", busy_m, 1'b0);
          chk1("abort_done", done_m, 1'b0);
          chk1("abort_pass", pass_m, 1'b0);
          chk16("abort_sig", sig_m, s);
          @(posedge clk); #1;
          chk16("abort_sig_hold", sig_m, s);
          chk1("abort_idle", busy_m, 1'b0);
          exp_sig = s;
          obs_sig = sig_m;
          return;
        end
        case (mode)
          M_ZERO:  r = 16'h0000;
          M_LOOP:  r = (c >= lat) ? hist[c - lat] : 16'($urandom);
          default: r = 16'($urandom);
        endcase
        if (c == flip_at) r = r ^ 16'h0010;
        drive(st, 1'b0, r);
        if (c >= lat) s = galois(s) ^ r;
      end else begin
        chk1("done_rise", done_m, 1'b1);
        chk1("done_busy", busy_m, 1'b0);
        chk16("done_sig", sig_m, s);
        chk16("done_stim", stim_m, stim_model[np]);
        chk1("done_pass", pass_m, pass_expect(s));
        obs_sig = sig_m;
        drive(1'b0, 1'b0, 16'h0000);
      end
    end
    exp_sig = s;
  endtask

  logic [15:0] e_sig, o_sig, e_clean, e_flip;

  initial begin
    stim_model[0] = 16'hACE1;
    for (int i = 1; i <= NP_A; i++) stim_model[i] = galois(stim_model[i-1]);
    sel = 1'b0;
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; resp_a = 16'h0000;
    start_b = 1'b0; abort_b = 1'b0; resp_b = 16'h0000;
    repeat (2) @(posedge clk);
    #1 check_reset("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 check_reset("post_reset");

    run(NP_A, LAT_A, M_ZERO, -1, -1, 1'b0, e_sig, o_sig);
    run(NP_A, LAT_A, M_RAND, -1, -1, 1'b0, e_sig, o_sig);
    run(NP_A, LAT_A, M_RAND, -1, -1, 1'b0, e_sig, o_sig);
    run(NP_A, LAT_A, M_LOOP, -1, -1, 1'b0, e_clean, o_sig);
    run(NP_A, LAT_A, M_LOOP, -1, 5, 1'b0, e_flip, o_sig);
    vectors++;
    assert (o_sig !== e_clean) else begin
      miscompares++;
      $error("FAIL flip_differs: observed %h expected not %h", o_sig, e_clean);
    end
    run(NP_A, LAT_A, M_LOOP, 10, -1, 1'b0, e_sig, o_sig);
    run(NP_A, LAT_A, M_LOOP, -1, -1, 1'b0, e_sig, o_sig);
    chk16("rerun_after_abort", o_sig, e_clean);

    // START held through the whole run: one run only, DONE then holds.
    run(NP_A, LAT_A, M_RAND, -1, -1, 1'b1, e_sig, o_sig);
    @(posedge clk); #1;
    chk1("held_start_done", done_a, 1'b1);
    chk1("held_start_busy", busy_a, 1'b0);
    chk16("held_start_sig", sig_a, e_sig);

    // ABORT from DONE, then START+ABORT together in IDLE.
    drive(1'b0, 1'b1, 16'h0000);
    @(posedge clk); #1 drive(1'b0, 1'b0, 16'h0000);
    chk1("abort_from_done", done_a, 1'b0);
    chk16("abort_from_done_sig", sig_a, e_sig);
    drive(1'b1, 1'b1, 16'h0000);
    @(posedge clk); #1 drive(1'b0, 1'b0, 16'h0000);
    chk1("start_abort_busy", busy_a, 1'b0);
    @(posedge clk); #1;
    chk1("start_abort_busy2", busy_a, 1'b0);
    chk1("start_abort_done2", done_a, 1'b0);

    // Zero-latency instance: FLUSH is skipped.
    sel = 1'b1;
    run(NP_B, LAT_B, M_RAND, -1, -1, 1'b0, e_sig, o_sig);
    run(NP_B, LAT_B, M_LOOP, -1, -1, 1'b0, e_sig, o_sig);
    sel = 1'b0;

    // Asynchronous reset during FLUSH.
    @(posedge clk); #1 drive(1'b1, 1'b0, 16'h1234);
    @(posedge clk); #1 drive(1'b0, 1'b0, 16'h1234);
    repeat (NP_A + 1) @(posedge clk);
    #1;
    chk1("flush_busy", busy_a, 1'b1);
    chk16("flush_stim", stim_a, stim_model[NP_A]);
    rst_n = 1'b0;
    #1 check_reset("flush_reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("after_reset_busy", busy_a, 1'b0);
    chk1("after_reset_done", done_a, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
